// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANES = 4;
endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-lane word memory: per-lane synchronous write, combinational read.
// Latency: write lands on the clock edge, read is same-cycle.
// Backpressure: none; always ready. Contents are not reset.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = 7,
  parameter int BYTE_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic [LANES-1:0]              we,
  input  logic [WORD_ADDR_WIDTH-1:0]    addr,
  input  logic [LANES*BYTE_WIDTH-1:0]   wdata,
  output logic [LANES*BYTE_WIDTH-1:0]   rdata
);
  logic [LANES*BYTE_WIDTH-1:0] mem [2**WORD_ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// RV32I load/store responder with WAIT_CYCLES busy cycles; response after WAIT_CYCLES+1 edges.
// Backpressure: one request at a time, response held until RespReady. Option: DMEM_MISALIGN_CHECK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int FUNCT3_WIDTH  = 3,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [ADDRESS_WIDTH-1:0] ReqAddr,
  input  logic [FUNCT3_WIDTH-1:0]  ReqFunct3,
  input  logic [DATA_WIDTH-1:0]    ReqWData,
  output logic                     RespValid,
  input  logic                     RespReady,
  output logic [DATA_WIDTH-1:0]    RespRData,
  output logic                     RespErr
);
  localparam int HW = 2 * BYTE_WIDTH;

  dmem_state_t              state;
  logic [3:0]               cnt;
  logic                     wr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [FUNCT3_WIDTH-1:0]  f3_q;
  logic [DATA_WIDTH-1:0]    wdat_q;

  logic [1:0]            size;
  logic [1:0]            lane;
  logic                  legal_f3;
  logic                  misalign;
  logic                  err;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [BYTE_WIDTH-1:0] rd_byte;
  logic [HW-1:0]         rd_half;
  logic [DATA_WIDTH-1:0] load_data;

  assign ReqReady  = (state == IDLE);
  assign RespValid = (state == RESP);

  assign size     = f3_q[1:0];
  assign legal_f3 = wr_q ? (f3_q <= F3_W) : (f3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

  // Halfword/word accesses always use the naturally aligned lane; misaligned bits are dropped.
  always_comb begin
    lane = addr_q[1:0];
    if (size == 2'b01) lane = {addr_q[1], 1'b0};
    else if (size == 2'b10) lane = 2'b00;
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((size == 2'b01) && addr_q[0]) || ((size == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err = !legal_f3 || misalign;

  always_comb begin
    be        = '0;
    ram_wdata = wdat_q;
    case (size)
      2'b00: begin
        be        = LANES'(1) << lane;
        ram_wdata = {LANES{wdat_q[BYTE_WIDTH-1:0]}};
      end
      2'b01: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdat_q[HW-1:0]}};
      end
      default: be = '1;
    endcase
    if (!(state == BUSY && cnt == 4'd0 && wr_q && !err)) be = '0;
  end

  dmem_byte_ram #(
    .WORD_ADDR_WIDTH(ADDRESS_WIDTH - 2),
    .BYTE_WIDTH     (BYTE_WIDTH)
  ) u_ram (
    .clk  (CLK),
    .we   (be),
    .addr (addr_q[ADDRESS_WIDTH-1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign rd_byte = ram_rdata[lane*BYTE_WIDTH +: BYTE_WIDTH];
  assign rd_half = lane[1] ? ram_rdata[DATA_WIDTH-1 -: HW] : ram_rdata[HW-1:0];

  always_comb begin
    case (size)
      2'b00:   load_data = {{(DATA_WIDTH-BYTE_WIDTH){~f3_q[2] & rd_byte[BYTE_WIDTH-1]}}, rd_byte};
      2'b01:   load_data = {{(DATA_WIDTH-HW){~f3_q[2] & rd_half[HW-1]}}, rd_half};
      default: load_data = ram_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      f3_q      <= '0;
      wdat_q    <= '0;
      RespRData <= '0;
      RespErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ReqValid) begin
          wr_q   <= ReqWrite;
          addr_q <= ReqAddr;
          f3_q   <= ReqFunct3;
          wdat_q <= ReqWData;
          cnt    <= 4'(WAIT_CYCLES);
          state  <= BUSY;
        end
        BUSY: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          RespRData <= (err || wr_q) ? '0 : load_data;
          RespErr   <= err;
          state     <= RESP;
        end
        RESP: if (RespReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Handshaked data-memory responder for the RISC-V core's load/store path. It accepts one load or store request at a time and applies RV32I byte/halfword/word semantics: lane-aligned byte-enable writes, and sign- or zero-extended reads. It answers after a programmable number of wait states and holds each response until the requester consumes it. This makes it the memory end of the core's load/store interface, replacing the zero-latency array once the datapath is pipelined.

## Interface
Parameters:
- ADDRESS_WIDTH, 9, byte-address width; depth is 2^(ADDRESS_WIDTH-2) words
- DATA_WIDTH, 32, word width (fixed at 32, four byte lanes)
- BYTE_WIDTH, 8, lane width
- FUNCT3_WIDTH, 3, access-type code width
- WAIT_CYCLES, 2, extra busy cycles per access (0..15)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-low
- ReqValid  in  1  request present
- ReqReady  out  1  request accepted this cycle when ReqValid is also high
- ReqWrite  in  1  1 = store, 0 = load
- ReqAddr  in  ADDRESS_WIDTH  byte address
- ReqFunct3  in  FUNCT3_WIDTH  RV32I funct3 (loads: 000/001/010/100/101; stores: 000/001/010)
- ReqWData  in  DATA_WIDTH  store data, right-justified
- RespValid  out  1  response present
- RespReady  in  1  requester consumes response
- RespRData  out  DATA_WIDTH  extended load data; 0 for stores and errors
- RespErr  out  1  access rejected; no memory effect

## Operation
- FSM states are IDLE, BUSY and RESP. ReqReady = (state == IDLE). No overlap between requests.
- IDLE: when ReqValid is high, capture ReqWrite, ReqAddr, ReqFunct3 and ReqWData; load the wait counter with WAIT_CYCLES; go to BUSY.
- BUSY: while the counter is nonzero, decrement it. When the counter is 0, perform the access at the next edge, register RespRData and RespErr, and go to RESP.
- RESP: hold RespValid, RespRData and RespErr stable. When RespReady is high, go to IDLE. A ReqValid in that same cycle is not accepted, because ReqReady is 0.
- Lane selection is little-endian; the word index is addr[ADDRESS_WIDTH-1:2].
  - Byte access: lane addr[1:0].
  - Halfword access: lanes {addr[1],0} and {addr[1],1}.
  - Word access: all four lanes.
- Store: ReqWData[7:0] is replicated to the selected byte lane, or ReqWData[15:0] to the selected half. Only the enabled lanes are written.
- Load: extract the byte or half from the word. funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- Illegal funct3: loads 011/110/111 and stores with funct3 above 010. Response is RespErr=1, RespRData=0, and no write.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, ReqReady=1, RespValid=0, RespRData=0, RespErr=0, counter 0.
- Latency: RespValid rises WAIT_CYCLES+1 edges after the accepting edge. With WAIT_CYCLES=0 it rises on the next edge.
- The store commits on the BUSY→RESP edge. The read uses the array contents before that edge.
- Throughput: one access per WAIT_CYCLES+3 cycles when RespReady is held high.
- Reset asserted mid-operation forces IDLE immediately.
  - A store not yet committed is dropped.
  - A committed store persists.
  - A pending response is discarded.
- Request inputs are ignored outside IDLE. Response outputs must not change while RespValid=1 and RespReady=0.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined: a halfword with addr[0]=1, or a word with addr[1:0]≠00, returns RespErr=1, RespRData=0, and no write.
- DMEM_MISALIGN_CHECK_EN undefined: misaligned low address bits are ignored. Halfword clears addr[0]; word clears addr[1:0]. RespErr is raised only for illegal funct3.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101);
  - the lane-count constant (4).
- One sub-module, dmem_byte_ram: four BYTE_WIDTH lanes, per-lane synchronous write enable, combinational word read. The FSM, lane steering and extension stay in data_mem_responder.

## Test plan
- Reset, then SW 0xDEADBEEF to addr 0x010, then LW from 0x010 with WAIT_CYCLES=2 → RespValid 3 edges after acceptance, RespRData=0xDEADBEEF, RespErr=0.
- SB 0x000000AB to 0x013 over word 0x11223344 at 0x010, then LW → 0xAB223344. Then LB from 0x013 → 0xFFFFFFAB; LBU → 0x000000AB.
- SH 0x8001 to 0x012, then LH from 0x012 → 0xFFFF8001; LHU → 0x00008001.
- With the macro defined, LW from 0x011 → RespErr=1, RespRData=0. SW to 0x011 leaves the word unchanged. Without the macro, LW from 0x011 returns the word at 0x010.
- Hold RespReady=0 for 5 cycles in RESP with ReqValid=1 → outputs stable, ReqReady=0, no second acceptance. Release → IDLE one edge later, then the request is accepted.
- Assert RST low during BUSY of SW 0x12345678 to 0x020 (prior value 0) → RespValid=0 and ReqReady=1 immediately; a later LW from 0x020 returns 0.
